// File: rtl/instr_loader_if.sv
// Host byte-stream handshake plus the instruction-memory write port of the loader.
// The host side uses master; the loader uses slave.
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a host byte stream little-endian into 32-bit words, writes them to instruction memory
// from word 0 upward, and flags the first word the core's decoder cannot execute.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] illegal_addr
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(MAX_WORDS);

  state_t      state;
  state_t      next_state;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        accept;
  logic        write_en;
  logic        load_start;

  // Mirrors the opcode/funct3 combinations the control decoder implements.
  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (opcode)
      7'b0110011: ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b111) || (funct3 == 3'b101);
      7'b0010011: ok = (funct3 == 3'b010) || (funct3 == 3'b111) || (funct3 == 3'b000);
      7'b0100011: ok = (funct3 == 3'b010);
      7'b0011011: ok = 1'b1;
      7'b0001011: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    bus.byte_ready = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = '0;
    bus.imem_wdata = '0;
    busy           = 1'b0;
    done           = 1'b0;
    accept         = 1'b0;
    write_en       = 1'b0;
    load_start     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RECV;
          load_start = 1'b1;
        end
      end
      RECV: begin
        busy           = 1'b1;
        bus.byte_ready = 1'b1;
        accept         = bus.byte_valid;
        if (accept && (lane == 2'd3)) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        // An all-zero word is the end-of-program marker and is never stored.
        if (word == 32'h0000_0000) begin
          next_state = DONE;
        end else begin
          write_en       = 1'b1;
          bus.imem_we    = 1'b1;
          bus.imem_addr  = word_count[ADDR_W-1:0];
          bus.imem_wdata = word;
          next_state     = ((word_count + 1'b1) == LAST_COUNT) ? DONE : RECV;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = RECV;
          load_start = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The 2-bit lane index wraps to 0 after the 4th byte, so RECV always resumes at lane 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane         <= '0;
      word         <= '0;
      word_count   <= '0;
      illegal      <= 1'b0;
      illegal_addr <= '0;
    end else begin
      if (load_start) begin
        lane         <= '0;
        word         <= '0;
        word_count   <= '0;
        illegal      <= 1'b0;
        illegal_addr <= '0;
      end
      if (accept) begin
        word[{lane, 3'b000} +: 8] <= bus.byte_data;
        lane                      <= lane + 2'd1;
      end
      if (write_en) begin
        word_count <= word_count + 1'b1;
        if (!is_legal(word[6:0], word[14:12]) && !illegal) begin
          illegal      <= 1'b1;
          illegal_addr <= word_count[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a full-size instance plus a 4-word instance for the capacity limit.
module tb_instr_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tb_valid = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic tb_start = 1'b0;
  logic sel = 1'b0;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  int last_acc = 0;

  logic [8:0] word_count, word_count_c;
  logic busy, done, illegal, busy_c, done_c, illegal_c;
  logic [7:0] illegal_addr, illegal_addr_c;
  logic cur_ready, cur_done;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          exp_cyc[$];
  logic [7:0]  cap_addr[$];
  logic [31:0] cap_data[$];

  instr_loader_if #(.ADDR_W(8)) bus ();
  instr_loader_if #(.ADDR_W(8)) bus_c ();

  assign bus.byte_valid   = tb_valid && !sel;
  assign bus.byte_data    = tb_data;
  assign bus_c.byte_valid = tb_valid && sel;
  assign bus_c.byte_data  = tb_data;
  assign cur_ready = sel ? bus_c.byte_ready : bus.byte_ready;
  assign cur_done  = sel ? done_c : done;

  instr_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(tb_start && !sel), .bus(bus),
    .word_count(word_count), .busy(busy), .done(done),
    .illegal(illegal), .illegal_addr(illegal_addr)
  );

  instr_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut_cap (
    .clk(clk), .reset(reset), .start(tb_start && sel), .bus(bus_c),
    .word_count(word_count_c), .busy(busy_c), .done(done_c),
    .illegal(illegal_c), .illegal_addr(illegal_addr_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus_c.imem_we) begin
      cap_addr.push_back(bus_c.imem_addr);
      cap_data.push_back(bus_c.imem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); exp_cyc.delete();
    cap_addr.delete(); cap_data.delete();
  endtask

  task automatic start_load();
    @(negedge clk);
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int n;
    @(negedge clk);
    tb_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tb_start = poke && (g == 0);
      @(negedge clk);
    end
    tb_start = 1'b0;
    tb_valid = 1'b1;
    tb_data  = b;
    n = 0;
    while (!cur_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) begin
      checkOutput("byte_ready_wait", {63'd0, cur_ready}, 64'd1);
      tb_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    tb_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int max_gap, input bit poke);
    int gap;
    for (int k = 0; k < 4; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (poke && k == 1 && gap == 0) gap = 1;
      send_byte(w[8*k +: 8], gap, poke && (k == 1));
    end
    if (w != 32'h0) exp_cyc.push_back(last_acc);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!cur_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_reached", {63'd0, cur_done}, 64'd1);
  endtask

  task automatic check_writes(input string p, input logic [31:0] prog[3]);
    checkOutput({p, "_nwrites"}, 64'(wr_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_addr%0d", p, i),
                  (i < wr_addr.size()) ? 64'(wr_addr[i]) : 64'hDEAD, 64'(i));
      checkOutput($sformatf("%s_data%0d", p, i),
                  (i < wr_data.size()) ? 64'(wr_data[i]) : 64'hDEAD, 64'(prog[i]));
    end
  endtask

  task automatic check_zero(input string p);
    checkOutput({p, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({p, "_done"}, {63'd0, done}, 64'd0);
    checkOutput({p, "_ready"}, {63'd0, bus.byte_ready}, 64'd0);
    checkOutput({p, "_we"}, {63'd0, bus.imem_we}, 64'd0);
    checkOutput({p, "_addr"}, 64'(bus.imem_addr), 64'd0);
    checkOutput({p, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    checkOutput({p, "_count"}, 64'(word_count), 64'd0);
    checkOutput({p, "_illegal"}, {63'd0, illegal}, 64'd0);
    checkOutput({p, "_ill_addr"}, 64'(illegal_addr), 64'd0);
  endtask

  logic [31:0] prog_basic[3] = '{32'h0050_0093, 32'h0020_81B3, 32'h0020_A023};
  logic [31:0] prog_bad[3]   = '{32'h0050_0093, 32'h0000_10B7, 32'h0000_2003};
  logic [31:0] sweep_word[12] = '{32'h0000_7033, 32'h0000_5033, 32'h0000_1033, 32'h0000_7013,
                                  32'h0000_2013, 32'h0000_5013, 32'h0000_2023, 32'h0000_0023,
                                  32'h0000_601B, 32'h0000_300B, 32'h0000_006F, 32'h0000_4033};
  logic sweep_bad[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] prog_cap[5] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                               32'h0040_0213, 32'h0050_0293};

  initial begin
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Gap-free load with cycle-exact write latency.
    start_load();
    clear_log();
    for (int i = 0; i < 3; i++) applyStimulus(prog_basic[i], 0, 1'b0);
    applyStimulus(32'h0, 0, 1'b0);
    wait_done();
    check_writes("basic", prog_basic);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("latency%0d", i),
                  (i < wr_cyc.size() && i < exp_cyc.size()) ? 64'(wr_cyc[i]) : 64'hDEAD,
                  (i < exp_cyc.size()) ? 64'(exp_cyc[i]) : 64'hBEEF);
    end
    checkOutput("basic_count", 64'(word_count), 64'd3);
    checkOutput("basic_illegal", {63'd0, illegal}, 64'd0);
    checkOutput("basic_busy", {63'd0, busy}, 64'd0);

    // Restart from DONE, then a program with two unsupported words.
    start_load();
    checkOutput("restart_done", {63'd0, done}, 64'd0);
    checkOutput("restart_busy", {63'd0, busy}, 64'd1);
    checkOutput("restart_count", 64'(word_count), 64'd0);
    clear_log();
    for (int i = 0; i < 3; i++) applyStimulus(prog_bad[i], 0, 1'b0);
    applyStimulus(32'h0, 0, 1'b0);
    wait_done();
    check_writes("bad", prog_bad);
    checkOutput("bad_illegal", {63'd0, illegal}, 64'd1);
    checkOutput("bad_ill_addr", 64'(illegal_addr), 64'd1);
    checkOutput("bad_count", 64'(word_count), 64'd3);
    start_load();
    checkOutput("restart_illegal", {63'd0, illegal}, 64'd0);
    checkOutput("restart_ill_addr", 64'(illegal_addr), 64'd0);
    applyStimulus(32'h0, 0, 1'b0);
    wait_done();

    // One word per load across the decoder's opcode/funct3 table.
    for (int i = 0; i < 12; i++) begin
      start_load();
      clear_log();
      applyStimulus(sweep_word[i], 0, 1'b0);
      applyStimulus(32'h0, 0, 1'b0);
      wait_done();
      checkOutput($sformatf("sweep%0d_illegal", i), {63'd0, illegal}, {63'd0, sweep_bad[i]});
      checkOutput($sformatf("sweep%0d_count", i), 64'(word_count), 64'd1);
    end

    // Random byte gaps with start pulsed while receiving.
    start_load();
    clear_log();
    for (int i = 0; i < 3; i++) applyStimulus(prog_basic[i], 10, 1'b1);
    applyStimulus(32'h0, 10, 1'b0);
    wait_done();
    check_writes("stall", prog_basic);
    checkOutput("stall_count", 64'(word_count), 64'd3);

    // Capacity limit on the 4-word instance.
    sel = 1'b1;
    start_load();
    clear_log();
    for (int i = 0; i < 4; i++) applyStimulus(prog_cap[i], 0, 1'b0);
    wait_done();
    checkOutput("cap_ready", {63'd0, bus_c.byte_ready}, 64'd0);
    checkOutput("cap_count", 64'(word_count_c), 64'd4);
    checkOutput("cap_nwrites", 64'(cap_addr.size()), 64'd4);
    checkOutput("cap_addr3", (cap_addr.size() > 3) ? 64'(cap_addr[3]) : 64'hDEAD, 64'd3);
    checkOutput("cap_data3", (cap_data.size() > 3) ? 64'(cap_data[3]) : 64'hDEAD, 64'(prog_cap[3]));
    @(negedge clk);
    tb_valid = 1'b1;
    tb_data  = prog_cap[4][7:0];
    repeat (6) @(negedge clk);
    tb_valid = 1'b0;
    checkOutput("cap_fifth_ready", {63'd0, bus_c.byte_ready}, 64'd0);
    checkOutput("cap_fifth_nwrites", 64'(cap_addr.size()), 64'd4);
    checkOutput("cap_fifth_count", 64'(word_count_c), 64'd4);
    sel = 1'b0;

    // Reset in the middle of the second word.
    start_load();
    clear_log();
    applyStimulus(32'h0050_0093, 0, 1'b0);
    send_byte(8'hB3, 0, 1'b0);
    send_byte(8'h81, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_nwrites", 64'(wr_addr.size()), 64'd1);
    start_load();
    clear_log();
    applyStimulus(32'h0020_A023, 0, 1'b0);
    applyStimulus(32'h0, 0, 1'b0);
    wait_done();
    checkOutput("after_reset_addr", (wr_addr.size() > 0) ? 64'(wr_addr[0]) : 64'hDEAD, 64'd0);
    checkOutput("after_reset_data", (wr_data.size() > 0) ? 64'(wr_data[0]) : 64'hDEAD, 64'h0020_A023);
    checkOutput("after_reset_count", 64'(word_count), 64'd1);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
